// File: rtl/c2_line_master.sv
// Cache-side initiator for the C2/D2/A2 line bus: one READ_LINE or WRITE_LINE at a time, 8 x 16-bit beats.
// Optional response watchdog is compiled in with `define C2M_TIMEOUT_EN.
module c2_line_master #(
  parameter int ADDR_W         = 15,
  parameter int BEATS          = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [16*BEATS-1:0]   req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [16*BEATS-1:0]   resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_W-1:0]     A2,
  inout  wire  [15:0]           D2,
  inout  wire  [1:0]            C2
);

  localparam int LINE_W = 16 * BEATS;
  localparam int CNT_W  = $clog2(BEATS);

  localparam logic [1:0] C2_NOP      = 2'd0;
  localparam logic [1:0] C2_RESPONSE = 2'd1;
  localparam logic [1:0] C2_READ     = 2'd2;
  localparam logic [1:0] C2_WRITE    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_CMD, S_RD_TURN, S_RD_DATA, S_WR_DATA, S_WR_ACK, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [LINE_W-1:0]   wdata_q, line_q, line_nxt;
  logic                resp_seen, last_beat, tmo_hit;
  logic                c2_oe, d2_oe;
  logic [1:0]          c2_out;
  logic [15:0]         wbeat, d2_out;

  assign C2 = c2_oe ? c2_out : 2'bzz;
  assign D2 = d2_oe ? d2_out : 16'hzzzz;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_DONE);
  assign last_beat  = (cnt == CNT_W'(BEATS - 1));
  assign wbeat      = wdata_q[{cnt, 4'b0000} +: 16];

  // X/Z on C2 falls through the if and counts as not-RESPONSE
  always_comb begin
    resp_seen = 1'b0;
    if (C2 == C2_RESPONSE) resp_seen = 1'b1;
  end

  // Even byte of the line travels on the upper half of D2
  always_comb begin
    line_nxt = line_q;
    if (state == S_RD_DATA && resp_seen)
      line_nxt[{cnt, 4'b0000} +: 16] = {D2[7:0], D2[15:8]};
  end

`ifdef C2M_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo;
  logic             err_q;

  assign tmo_hit  = (tmo == TMO_W'(TIMEOUT_CYCLES));
  assign resp_err = resp_valid & err_q;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      tmo   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= tmo_hit & ~resp_seen;
      if ((state == S_RD_DATA || state == S_WR_ACK) && !resp_seen && !tmo_hit)
        tmo <= tmo + 1'b1;
      else
        tmo <= '0;
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    c2_oe     = 1'b0;
    c2_out    = C2_NOP;
    d2_oe     = 1'b0;
    d2_out    = {wbeat[7:0], wbeat[15:8]};
    case (state)
      S_IDLE: begin
        c2_oe = 1'b1;
        if (req_valid) state_nxt = req_write ? S_WR_DATA : S_RD_CMD;
      end
      S_RD_CMD: begin
        c2_oe     = 1'b1;
        c2_out    = C2_READ;
        state_nxt = S_RD_TURN;
      end
      S_RD_TURN: state_nxt = S_RD_DATA;
      S_RD_DATA: begin
        if ((resp_seen && last_beat) || (!resp_seen && tmo_hit)) state_nxt = S_DONE;
      end
      S_WR_DATA: begin
        c2_oe  = 1'b1;
        c2_out = C2_WRITE;
        d2_oe  = 1'b1;
        if (last_beat) state_nxt = S_WR_ACK;
      end
      S_WR_ACK: begin
        if (resp_seen || tmo_hit) state_nxt = S_DONE;
      end
      S_DONE: begin
        c2_oe     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      cnt        <= '0;
      A2         <= '0;
      resp_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req_valid) begin
        A2  <= req_addr;
        cnt <= '0;
      end else if ((state == S_RD_DATA && resp_seen) || state == S_WR_DATA) begin
        cnt <= last_beat ? '0 : cnt + 1'b1;
      end
      if (state == S_RD_DATA && state_nxt == S_DONE) resp_rdata <= line_nxt;
    end
  end

  // Line buffers: cleared per read so beats lost to a timeout read back as 0
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req_valid) wdata_q <= req_wdata;
    if (state == S_RD_CMD) line_q <= '0;
    else                   line_q <= line_nxt;
  end

endmodule
